// File: rtl/gcd_bank_pkg.sv
// Shared constants for the GCD operand/result bank: address map, register bit
// positions and the launch FSM states.
package gcd_bank_pkg;

  localparam int unsigned WORD_W    = 64;
  localparam int unsigned WORD_IDX_W = 5;

  localparam int unsigned SEG_CTRL  = 0;
  localparam int unsigned SEG_ARG_A = 1;
  localparam int unsigned SEG_ARG_B = 2;
  localparam int unsigned SEG_RES0  = 3;

  localparam int unsigned W_CTRL    = 0;
  localparam int unsigned W_STATUS  = 1;
  localparam int unsigned W_CYCLES  = 2;
  localparam int unsigned W_ID      = 3;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_CLR    = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  localparam int unsigned ST_BUSY     = 0;
  localparam int unsigned ST_DONE     = 1;
  localparam int unsigned ST_ERR_RO   = 2;
  localparam int unsigned ST_ERR_BUSY = 3;
  localparam int unsigned ST_ERR_TMO  = 4;
  localparam int unsigned STATUS_W    = 5;

  localparam logic [15:0] ID_MAGIC = 16'h6CD1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } state_t;

endpackage

// File: rtl/gcd_bank_snapshot.sv
// Result snapshot store: captures all core result vectors in one cycle and
// offers a combinational 64-bit word read port, zero-extended past RES_W.
module gcd_bank_snapshot
  import gcd_bank_pkg::*;
#(
  parameter int unsigned RES_W     = 1284,
  parameter int unsigned NUM_RES   = 14,
  parameter int unsigned SEG_WORDS = 32,
  parameter int unsigned VEC_W     = (NUM_RES > 1) ? $clog2(NUM_RES) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_capture,
  input  logic [NUM_RES*RES_W-1:0]   i_results,
  input  logic [VEC_W-1:0]           i_vec,
  input  logic [WORD_IDX_W-1:0]      i_word,
  output logic [WORD_W-1:0]          o_word_c
);

  localparam int unsigned PAD_W = SEG_WORDS * WORD_W;

  logic [RES_W-1:0] r_snap [NUM_RES];
  logic [PAD_W-1:0] w_pad;

  // Storage is intentionally not reset; it only means something after a capture.
  always_ff @(posedge i_clk) begin
    if (i_capture) begin
      for (int unsigned k = 0; k < NUM_RES; k++) begin
        r_snap[k] <= i_results[k*RES_W +: RES_W];
      end
    end
  end

  always_comb begin
    w_pad    = '0;
    o_word_c = '0;
    if (32'(i_vec) < NUM_RES) begin
      w_pad = PAD_W'(r_snap[i_vec]);
    end
    if (32'(i_word) < SEG_WORDS) begin
      o_word_c = w_pad[32'(i_word)*WORD_W +: WORD_W];
    end
  end

endmodule

// File: rtl/gcd_operand_bank.sv
// SRAM-mapped operand/result bank in front of the GCD core: host-written
// operands, launch/run FSM with cycle counter, coherent result snapshots, IRQ.
module gcd_operand_bank
  import gcd_bank_pkg::*;
#(
  parameter int unsigned ARG_W       = 1279,
  parameter int unsigned RES_W       = 1284,
  parameter int unsigned NUM_RES     = 14,
  parameter int unsigned SEG_WORDS   = 32,
  parameter int unsigned SEG_BITS    = 5,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       SRAM_CEn,
  input  logic [31:0]                SRAM_ADDR,
  input  logic [63:0]                SRAM_WDATA,
  input  logic                       SRAM_WEn,
  input  logic [7:0]                 SRAM_WBEn,
  output logic [63:0]                SRAM_RDATA,
  output logic [ARG_W-1:0]           ARG_A,
  output logic [ARG_W-1:0]           ARG_B,
  output logic                       START,
  input  logic                       DONE,
  input  logic [NUM_RES*RES_W-1:0]   RESULTS,
  output logic                       IRQ
);

  localparam int unsigned VEC_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;

  logic [SEG_WORDS-1:0][WORD_W-1:0] r_arg_a;
  logic [SEG_WORDS-1:0][WORD_W-1:0] r_arg_b;

  state_t        r_state;
  logic          r_start;
  logic          r_irq;
  logic [63:0]   r_rdata;
  logic [63:0]   r_cycles;
  logic          r_done_q;
  logic          r_done_f;
  logic          r_err_ro;
  logic          r_err_busy;
  logic          r_err_tmo;
  logic          r_irq_en;

  logic [WORD_IDX_W-1:0] w_word;
  logic [SEG_BITS-1:0]   w_seg;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_busy;
  logic                  w_seg_ctrl;
  logic                  w_seg_a;
  logic                  w_seg_b;
  logic                  w_seg_res;
  logic                  w_word_ok;
  logic                  w_ctrl_wr;
  logic                  w_start_req;
  logic                  w_clr;
  logic                  w_ro_wr;
  logic                  w_arg_wr;
  logic                  w_capture;
  logic [63:0]           w_bmask;
  logic [63:0]           w_cyc_next;
  logic [VEC_W-1:0]      w_res_vec;
  logic [WORD_W-1:0]     w_snap_word_c;
  logic [STATUS_W-1:0]   w_status;
  logic [63:0]           w_rdata_c;
  logic                  w_unused_addr;

  // Address decode; bits above the segment field alias.
  assign w_word        = SRAM_ADDR[7:3];
  assign w_seg         = SRAM_ADDR[8 +: SEG_BITS];
  assign w_unused_addr = ^{SRAM_ADDR[31:8+SEG_BITS], SRAM_ADDR[2:0]};
  assign w_wr          = ~SRAM_CEn & ~SRAM_WEn;
  assign w_rd          = ~SRAM_CEn &  SRAM_WEn;
  assign w_busy        = (r_state != S_IDLE);

  assign w_seg_ctrl = (32'(w_seg) == SEG_CTRL);
  assign w_seg_a    = (32'(w_seg) == SEG_ARG_A);
  assign w_seg_b    = (32'(w_seg) == SEG_ARG_B);
  assign w_seg_res  = (32'(w_seg) >= SEG_RES0) && (32'(w_seg) < SEG_RES0 + NUM_RES);
  assign w_res_vec  = VEC_W'(32'(w_seg) - SEG_RES0);
  assign w_word_ok  = (32'(w_word) < SEG_WORDS);

  assign w_ctrl_wr   = w_wr & w_seg_ctrl & (32'(w_word) == W_CTRL) & ~SRAM_WBEn[0];
  assign w_start_req = w_ctrl_wr & SRAM_WDATA[CTRL_START];
  assign w_clr       = w_ctrl_wr & SRAM_WDATA[CTRL_CLR];
  assign w_ro_wr     = w_wr & ((w_seg_ctrl & (32'(w_word) >= W_STATUS) & (32'(w_word) <= W_ID))
                               | w_seg_res);
  assign w_arg_wr    = w_wr & (w_seg_a | w_seg_b) & w_word_ok;

  assign w_capture  = (r_state == S_RUN) & DONE & ~r_done_q;
  assign w_cyc_next = (r_cycles == '1) ? r_cycles : r_cycles + 64'd1;

  always_comb begin
    for (int unsigned b = 0; b < 8; b++) begin
      w_bmask[b*8 +: 8] = {8{~SRAM_WBEn[b]}};
    end
  end

  // Operand storage is not reset; writes are dropped while a run is active.
  always_ff @(posedge CLK) begin
    if (w_arg_wr && !w_busy) begin
      if (w_seg_a) begin
        r_arg_a[w_word] <= (r_arg_a[w_word] & ~w_bmask) | (SRAM_WDATA & w_bmask);
      end else begin
        r_arg_b[w_word] <= (r_arg_b[w_word] & ~w_bmask) | (SRAM_WDATA & w_bmask);
      end
    end
  end

  assign ARG_A = ARG_W'(r_arg_a);
  assign ARG_B = ARG_W'(r_arg_b);

  gcd_bank_snapshot #(
    .RES_W     (RES_W),
    .NUM_RES   (NUM_RES),
    .SEG_WORDS (SEG_WORDS),
    .VEC_W     (VEC_W)
  ) u_snapshot (
    .i_clk     (CLK),
    .i_capture (w_capture),
    .i_results (RESULTS),
    .i_vec     (w_res_vec),
    .i_word    (w_word),
    .o_word_c  (w_snap_word_c)
  );

  always_comb begin
    w_status              = '0;
    w_status[ST_BUSY]     = w_busy;
    w_status[ST_DONE]     = r_done_f;
    w_status[ST_ERR_RO]   = r_err_ro;
    w_status[ST_ERR_BUSY] = r_err_busy;
    w_status[ST_ERR_TMO]  = r_err_tmo;
  end

  // Read mux sees pre-edge state, so same-edge updates are not visible.
  always_comb begin
    w_rdata_c = '0;
    if (w_seg_ctrl) begin
      case (w_word)
        5'(W_CTRL):   w_rdata_c[CTRL_IRQ_EN] = r_irq_en;
        5'(W_STATUS): w_rdata_c = 64'(w_status);
        5'(W_CYCLES): w_rdata_c = r_cycles;
        5'(W_ID):     w_rdata_c = {16'(ARG_W), 16'(RES_W), 16'(NUM_RES), ID_MAGIC};
        default:      w_rdata_c = '0;
      endcase
    end else if (w_seg_a && w_word_ok) begin
      w_rdata_c = r_arg_a[w_word];
    end else if (w_seg_b && w_word_ok) begin
      w_rdata_c = r_arg_b[w_word];
    end else if (w_seg_res) begin
      w_rdata_c = w_snap_word_c;
    end
  end

  // Control FSM, flags, counter and read register; CLR applies before any same-edge set.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_start    <= 1'b0;
      r_irq      <= 1'b0;
      r_rdata    <= '0;
      r_cycles   <= '0;
      r_done_q   <= 1'b0;
      r_done_f   <= 1'b0;
      r_err_ro   <= 1'b0;
      r_err_busy <= 1'b0;
      r_err_tmo  <= 1'b0;
      r_irq_en   <= 1'b0;
    end else begin
      if (w_rd) begin
        r_rdata <= w_rdata_c;
      end
      if (w_ctrl_wr) begin
        r_irq_en <= SRAM_WDATA[CTRL_IRQ_EN];
      end
      if (w_clr) begin
        r_done_f   <= 1'b0;
        r_err_ro   <= 1'b0;
        r_err_busy <= 1'b0;
        r_err_tmo  <= 1'b0;
      end
      if (w_ro_wr) begin
        r_err_ro <= 1'b1;
      end
      if (w_busy && (w_arg_wr || w_start_req)) begin
        r_err_busy <= 1'b1;
      end

      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_req) begin
            r_state  <= S_LAUNCH;
            r_cycles <= '0;
            r_start  <= 1'b1;
          end
        end
        S_LAUNCH: begin
          r_done_q <= DONE;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          r_cycles <= w_cyc_next;
          r_done_q <= DONE;
          if (w_capture) begin
            r_done_f <= 1'b1;
            r_state  <= S_IDLE;
          end else if (TIMEOUT_CYC != 0 && w_cyc_next == 64'(TIMEOUT_CYC)) begin
            r_err_tmo <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      r_irq <= r_irq_en & (r_done_f | r_err_tmo);
    end
  end

  assign START      = r_start;
  assign IRQ        = r_irq;
  assign SRAM_RDATA = r_rdata;

endmodule

// File: tb/tb_gcd_operand_bank.sv
// Bench for gcd_operand_bank: one instance without timeout, one with TIMEOUT_CYC=5,
// sharing the host bus but with separate chip enables and DONE inputs.
module tb_gcd_operand_bank;

  localparam int unsigned ARG_W   = 1279;
  localparam int unsigned RES_W   = 1284;
  localparam int unsigned NUM_RES = 14;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [1:0]               cen_n;
  logic [31:0]              addr;
  logic [63:0]              wdata;
  logic                     wen;
  logic [7:0]               wben;
  logic                     done0, done1;
  logic [NUM_RES*RES_W-1:0] results;

  logic [63:0]      rdata0, rdata1;
  logic [ARG_W-1:0] arg_a0, arg_b0, arg_a1, arg_b1;
  logic             start0, start1, irq0, irq1;

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  gcd_operand_bank #(.TIMEOUT_CYC(0)) u_dut0 (
    .CLK(clk), .RESET(rst), .SRAM_CEn(cen_n[0]), .SRAM_ADDR(addr), .SRAM_WDATA(wdata),
    .SRAM_WEn(wen), .SRAM_WBEn(wben), .SRAM_RDATA(rdata0), .ARG_A(arg_a0), .ARG_B(arg_b0),
    .START(start0), .DONE(done0), .RESULTS(results), .IRQ(irq0)
  );

  gcd_operand_bank #(.TIMEOUT_CYC(5)) u_dut1 (
    .CLK(clk), .RESET(rst), .SRAM_CEn(cen_n[1]), .SRAM_ADDR(addr), .SRAM_WDATA(wdata),
    .SRAM_WEn(wen), .SRAM_WBEn(wben), .SRAM_RDATA(rdata1), .ARG_A(arg_a1), .ARG_B(arg_b1),
    .START(start1), .DONE(done1), .RESULTS(results), .IRQ(irq1)
  );

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [63:0] d;
    logic [7:0]  be_n;
    string       name;
  } vec_t;

  function automatic vec_t mk(bit wr, logic [31:0] a, logic [63:0] d, logic [7:0] be_n, string name);
    vec_t v;
    v.wr = wr; v.a = a; v.d = d; v.be_n = be_n; v.name = name;
    return v;
  endfunction

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic bus_wr(input logic [1:0] tgt, input logic [31:0] a, input logic [63:0] d,
                        input logic [7:0] be_n);
    @(negedge clk);
    cen_n = ~tgt; wen = 1'b0; addr = a; wdata = d; wben = be_n;
    @(posedge clk); #1;
    cen_n = 2'b11; wen = 1'b1; wben = 8'hFF;
  endtask

  // Expected value is queued at issue and retired when the registered data appears.
  task automatic bus_rd(input bit sel, input logic [31:0] a, input logic [63:0] exp,
                        input string name);
    exp_q.push_back(exp);
    @(negedge clk);
    cen_n = sel ? 2'b01 : 2'b10; wen = 1'b1; addr = a;
    @(posedge clk); #1;
    cen_n = 2'b11;
    check64(name, sel ? rdata1 : rdata0, exp_q.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl[$];

    rst = 1'b1; cen_n = 2'b11; wen = 1'b1; wben = 8'hFF; addr = '0; wdata = '0;
    done0 = 1'b0; done1 = 1'b0; results = '0;
    repeat (2) @(posedge clk);
    #1;
    check64("rst_rdata", rdata0, 64'h0);
    check64("rst_start", 64'(start0), 64'h0);
    check64("rst_irq", 64'(irq0), 64'h0);
    @(negedge clk); rst = 1'b0;

    tbl.push_back(mk(1, 32'h0000_0100, 64'h0, 8'h00, "arg_a_w0_zero"));
    tbl.push_back(mk(1, 32'h0000_0100, 64'h1122_3344_5566_7788, 8'hF0, "arg_a_w0_masked"));
    tbl.push_back(mk(0, 32'h0000_0100, 64'h0000_0000_5566_7788, 8'h00, "arg_a_w0_rd"));
    tbl.push_back(mk(1, 32'h0000_0198, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, "arg_a_w19"));
    tbl.push_back(mk(0, 32'h0000_0198, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, "arg_a_w19_rd"));
    tbl.push_back(mk(1, 32'h0000_0208, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, "arg_b_w1"));
    tbl.push_back(mk(0, 32'h0000_0208, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, "arg_b_w1_rd"));
    tbl.push_back(mk(0, 32'h1000_0208, 64'hDEAD_BEEF_CAFE_F00D, 8'h00, "arg_b_alias_rd"));
    tbl.push_back(mk(0, 32'h0000_0018, 64'h04FF_0504_000E_6CD1, 8'h00, "id_rd"));
    tbl.push_back(mk(0, 32'h0000_1400, 64'h0, 8'h00, "unmapped_seg_rd"));
    tbl.push_back(mk(0, 32'h0000_0008, 64'h0, 8'h00, "status_clean"));
    tbl.push_back(mk(1, 32'h0000_0008, 64'h1, 8'h00, "status_write"));
    tbl.push_back(mk(0, 32'h0000_0008, 64'h4, 8'h00, "status_err_ro"));
    tbl.push_back(mk(1, 32'h0000_0000, 64'h2, 8'h00, "ctrl_clr"));
    tbl.push_back(mk(0, 32'h0000_0008, 64'h0, 8'h00, "status_after_clr"));
    tbl.push_back(mk(1, 32'h0000_0000, 64'h4, 8'hFF, "ctrl_no_byte0"));
    tbl.push_back(mk(0, 32'h0000_0000, 64'h0, 8'h00, "ctrl_be_gated"));
    tbl.push_back(mk(1, 32'h0000_0300, 64'h1, 8'h00, "snap_write"));
    tbl.push_back(mk(0, 32'h0000_0008, 64'h4, 8'h00, "status_snap_ro"));
    tbl.push_back(mk(1, 32'h0000_0000, 64'h2, 8'h00, "ctrl_clr2"));

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].wr) bus_wr(2'b11, tbl[i].a, tbl[i].d, tbl[i].be_n);
      else           bus_rd(1'b0, tbl[i].a, tbl[i].d, tbl[i].name);
    end
    check64("arg_a_low", arg_a0[63:0], 64'h0000_0000_5566_7788);
    check64("arg_a_top", 64'(arg_a0[ARG_W-1 -: 63]), 64'h7FFF_FFFF_FFFF_FFFF);
    check64("arg_b_w1", arg_b0[127:64], 64'hDEAD_BEEF_CAFE_F00D);

    // Run with capture on dut0; DONE rises so that capture lands on the 11th RUN edge.
    results[0*RES_W +: RES_W]  = RES_W'(16'hABCD);
    results[13*RES_W +: RES_W] = '1;
    bus_wr(2'b01, 32'h0, 64'h5, 8'h00);
    check64("start_pulse_hi", 64'(start0), 64'h1);
    @(posedge clk); #1;
    check64("start_pulse_lo", 64'(start0), 64'h0);
    bus_rd(1'b0, 32'h008, 64'h1, "busy_in_run");
    bus_wr(2'b01, 32'h208, 64'h0123, 8'h00);
    bus_rd(1'b0, 32'h208, 64'hDEAD_BEEF_CAFE_F00D, "arg_b_busy_drop");
    check64("arg_b_busy_port", arg_b0[127:64], 64'hDEAD_BEEF_CAFE_F00D);
    bus_wr(2'b01, 32'h0, 64'h5, 8'h00);
    bus_rd(1'b0, 32'h008, 64'h9, "err_busy_set");
    bus_wr(2'b01, 32'h0, 64'h6, 8'h00);
    bus_rd(1'b0, 32'h008, 64'h1, "err_busy_clr");
    repeat (3) @(posedge clk);
    #1 done0 = 1'b1;
    @(posedge clk); #1;
    results[0*RES_W +: RES_W] = RES_W'(16'h1234);
    check64("irq_lag", 64'(irq0), 64'h0);
    @(posedge clk); #1;
    check64("irq_set", 64'(irq0), 64'h1);
    bus_rd(1'b0, 32'h008, 64'h2, "status_done");
    bus_rd(1'b0, 32'h010, 64'd11, "cycles_run");
    bus_rd(1'b0, 32'h300, 64'hABCD, "snap_v0_w0");
    bus_rd(1'b0, 32'h10A0, 64'hF, "snap_v13_top");
    bus_rd(1'b0, 32'h0, 64'h4, "ctrl_irq_en");

    // Timeout on dut1 (DONE held low).
    bus_wr(2'b10, 32'h0, 64'h5, 8'h00);
    bus_rd(1'b1, 32'h008, 64'h1, "tmo_busy");
    bus_rd(1'b1, 32'h010, 64'h0, "tmo_cyc_start");
    repeat (3) @(posedge clk);
    bus_rd(1'b1, 32'h008, 64'h1, "tmo_not_early");
    bus_rd(1'b1, 32'h008, 64'h10, "tmo_flag");
    check64("tmo_irq", 64'(irq1), 64'h1);
    bus_rd(1'b1, 32'h010, 64'd5, "tmo_cycles");
    bus_wr(2'b10, 32'h0, 64'h7, 8'h00);
    bus_rd(1'b1, 32'h008, 64'h1, "clr_start_same_edge");
    repeat (4) @(posedge clk);
    bus_wr(2'b10, 32'h0, 64'h6, 8'h00);
    bus_rd(1'b1, 32'h008, 64'h10, "tmo_set_wins");

    // Reset mid-run on dut0 with DONE still high from the previous run.
    bus_wr(2'b01, 32'h0, 64'h5, 8'h00);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check64("rst_mid_rdata", rdata0, 64'h0);
    check64("rst_mid_start", 64'(start0), 64'h0);
    check64("rst_mid_irq", 64'(irq0), 64'h0);
    @(negedge clk); rst = 1'b0;
    bus_rd(1'b0, 32'h0, 64'h0, "rst_ctrl");
    bus_rd(1'b0, 32'h008, 64'h0, "rst_status");
    bus_rd(1'b0, 32'h010, 64'h0, "rst_cycles");
    bus_wr(2'b01, 32'h0, 64'h1, 8'h00);
    repeat (10) @(posedge clk);
    bus_rd(1'b0, 32'h008, 64'h1, "held_done_no_complete");
    done0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 done0 = 1'b1;
    repeat (2) @(posedge clk);
    bus_rd(1'b0, 32'h008, 64'h2, "rerise_complete");
    bus_rd(1'b0, 32'h300, 64'h1234, "snap_recaptured");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
